// File: rtl/apb_master_bridge_if.sv
// Bundles the local command/response channel and the APB bus of apb_master_bridge.
// The master modport is the bridge's view; the slave modport is the surrounding environment.
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: one local command becomes one SETUP/ACCESS transfer and one response strobe.
// A saturating wait counter aborts transfers whose slave never raises PREADY.
module apb_master_bridge #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic PCLK,
    input  logic PRESET,
    apb_master_bridge_if.master bus
);
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);
    localparam logic       TIMEOUT_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                state_q,       state_d;
    logic [7:0]            wait_cnt_q,    wait_cnt_d;
    logic                  cmd_ready_q,   cmd_ready_d;
    logic                  psel_q,        psel_d;
    logic                  penable_q,     penable_d;
    logic                  pwrite_q,      pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_err_q,     rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic [7:0]            wait_cnt_inc;

    // Saturate rather than wrap so a disabled timeout can never alias back to a small count.
    assign wait_cnt_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d     = ST_SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = bus.cmd_write;
                    paddr_d     = bus.cmd_addr;
                    pwdata_d    = bus.cmd_write ? bus.cmd_wdata : '0;
                    wait_cnt_d  = 8'd0;
                end
            end

            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end

            ST_ACCESS: begin
                // Completion is checked first so PREADY beats a coincident timeout.
                if (bus.PREADY) begin
                    state_d       = ST_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d     = bus.PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (TIMEOUT_EN && (wait_cnt_inc == TIMEOUT_LIMIT)) begin
                        state_d       = ST_RESP;
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end

            ST_RESP: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end

            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= 8'd0;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus randomized transfers
// checked against a latency/response model derived from the transfer rules.
module tb_apb_master_bridge;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int TO = 16;

    logic PCLK = 1'b0;
    logic PRESET;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    // Observations of the most recent do_xfer call
    int         obs_lat, obs_setup, obs_access;
    logic       obs_bus_bad, obs_en_bad, obs_hung;
    logic [7:0] obs_rdata;
    logic       obs_err, obs_to;

    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    // Issues one command and plays the APB slave: PREADY rises after nwait wait cycles.
    // While waiting, PSLVERR is driven to 'noise' and PRDATA to garbage.
    task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int nwait, input logic [DW-1:0] rdata, input logic slverr,
                           input logic noise);
        int  k;
        int  acc;
        bit  done;
        logic [DW-1:0] exp_pwdata;
        exp_pwdata  = wr ? wdata : '0;
        obs_setup   = 0; obs_access = 0; obs_lat = -1;
        obs_bus_bad = 0; obs_en_bad = 0; obs_hung = 0;
        obs_rdata   = '0; obs_err = 0; obs_to = 0;
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 50) begin
            @(negedge PCLK);
            k++;
        end
        if (k >= 50) obs_hung = 1;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom); bus.cmd_addr = AW'($urandom); bus.cmd_wdata = DW'($urandom);
        acc  = 0;
        done = 0;
        for (k = 0; k < 300 && !done; k++) begin
            if (bus.PENABLE && !bus.PSEL) obs_en_bad = 1;
            if (bus.PSEL) begin
                if (bus.PADDR !== addr || bus.PWRITE !== wr || bus.PWDATA !== exp_pwdata) obs_bus_bad = 1;
                if (!bus.PENABLE) obs_setup++;
                else obs_access++;
            end
            if (bus.rsp_valid === 1'b1) begin
                obs_lat = k + 1; obs_rdata = bus.rsp_rdata; obs_err = bus.rsp_err; obs_to = bus.rsp_timeout;
                done = 1;
            end
            if (bus.PSEL && bus.PENABLE) begin
                acc++;
                if (acc > nwait) begin
                    bus.PREADY = 1'b1; bus.PRDATA = rdata; bus.PSLVERR = slverr;
                end else begin
                    bus.PREADY = 1'b0; bus.PRDATA = DW'($urandom); bus.PSLVERR = noise;
                end
            end else begin
                bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
            end
            if (!done) @(negedge PCLK);
        end
        if (!done) obs_hung = 1;
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        $display("[TB] xfer wr=%0b addr=%0d wdata=%02h nwait=%0d -> lat=%0d rdata=%02h err=%0b to=%0b setup=%0d access=%0d",
                 wr, addr, wdata, nwait, obs_lat, obs_rdata, obs_err, obs_to, obs_setup, obs_access);
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        tests_run++; if (bus.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_cmd_ready: got %b expected 1", bus.cmd_ready); end
        tests_run++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) begin tests_failed++; $display("FAIL reset_in_psel_penable: got %b%b expected 00", bus.PSEL, bus.PENABLE); end
        PRESET = 1'b0;
        @(negedge PCLK);
        tests_run++; if (bus.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
        tests_run++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) begin tests_failed++; $display("FAIL reset_psel_penable: got %b%b expected 00", bus.PSEL, bus.PENABLE); end
        tests_run++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp: got v=%b e=%b t=%b expected 0", bus.rsp_valid, bus.rsp_err, bus.rsp_timeout); end
        tests_run++; if (bus.PADDR !== '0 || bus.PWDATA !== '0 || bus.PWRITE !== 1'b0 || bus.rsp_rdata !== '0) begin tests_failed++; $display("FAIL reset_data: got paddr=%h pwdata=%h pwrite=%b rdata=%h expected 0", bus.PADDR, bus.PWDATA, bus.PWRITE, bus.rsp_rdata); end
    endtask

    task automatic test_zero_wait_write();
        do_xfer(1'b1, 3'd4, 8'hAA, 0, 8'h77, 1'b0, 1'b0);
        tests_run++; if (obs_lat !== 3) begin tests_failed++; $display("FAIL zw_latency: got %0d expected 3", obs_lat); end
        tests_run++; if (obs_setup !== 1 || obs_access !== 1) begin tests_failed++; $display("FAIL zw_phases: got setup=%0d access=%0d expected 1/1", obs_setup, obs_access); end
        tests_run++; if (obs_bus_bad !== 1'b0) begin tests_failed++; $display("FAIL zw_bus: got bad=%b expected 0", obs_bus_bad); end
        tests_run++; if (obs_err !== 1'b0 || obs_rdata !== 8'h00) begin tests_failed++; $display("FAIL zw_rsp: got err=%b rdata=%02h expected 0/00", obs_err, obs_rdata); end
    endtask

    task automatic test_wait_read();
        do_xfer(1'b0, 3'd5, 8'hE1, 3, 8'h3C, 1'b0, 1'b0);
        tests_run++; if (obs_lat !== 6) begin tests_failed++; $display("FAIL wr_latency: got %0d expected 6", obs_lat); end
        tests_run++; if (obs_rdata !== 8'h3C) begin tests_failed++; $display("FAIL wr_rdata: got %02h expected 3c", obs_rdata); end
        tests_run++; if (obs_setup !== 1 || obs_access !== 4 || obs_en_bad !== 1'b0) begin tests_failed++; $display("FAIL wr_phases: got setup=%0d access=%0d en_bad=%b expected 1/4/0", obs_setup, obs_access, obs_en_bad); end
        tests_run++; if (obs_bus_bad !== 1'b0) begin tests_failed++; $display("FAIL wr_bus_stable: got bad=%b expected 0", obs_bus_bad); end
    endtask

    task automatic test_slave_error();
        do_xfer(1'b1, 3'd7, 8'h12, 0, 8'h00, 1'b1, 1'b0);
        tests_run++; if (obs_err !== 1'b1 || obs_to !== 1'b0) begin tests_failed++; $display("FAIL slverr: got err=%b to=%b expected 1/0", obs_err, obs_to); end
        do_xfer(1'b0, 3'd2, 8'h00, 2, 8'hC5, 1'b0, 1'b1);
        tests_run++; if (obs_err !== 1'b0 || obs_rdata !== 8'hC5) begin tests_failed++; $display("FAIL slverr_no_ready: got err=%b rdata=%02h expected 0/c5", obs_err, obs_rdata); end
    endtask

    task automatic test_timeout();
        do_xfer(1'b0, 3'd6, 8'h00, 1000, 8'hFF, 1'b0, 1'b1);
        tests_run++; if (obs_lat !== TO + 2) begin tests_failed++; $display("FAIL to_latency: got %0d expected %0d", obs_lat, TO + 2); end
        tests_run++; if (obs_err !== 1'b1 || obs_to !== 1'b1 || obs_rdata !== 8'h00) begin tests_failed++; $display("FAIL to_rsp: got err=%b to=%b rdata=%02h expected 1/1/00", obs_err, obs_to, obs_rdata); end
        tests_run++; if (obs_access !== TO) begin tests_failed++; $display("FAIL to_access_cycles: got %0d expected %0d", obs_access, TO); end
        do_xfer(1'b1, 3'd3, 8'h55, 1, 8'h00, 1'b0, 1'b0);
        tests_run++; if (obs_lat !== 4 || obs_err !== 1'b0 || obs_to !== 1'b0) begin tests_failed++; $display("FAIL to_next_cmd: got lat=%0d err=%b to=%b expected 4/0/0", obs_lat, obs_err, obs_to); end
        // PREADY on the very cycle the count would reach the limit: completion wins
        do_xfer(1'b0, 3'd1, 8'h00, TO - 1, 8'h9D, 1'b0, 1'b0);
        tests_run++; if (obs_lat !== TO + 2 || obs_to !== 1'b0 || obs_rdata !== 8'h9D) begin tests_failed++; $display("FAIL to_boundary: got lat=%0d to=%b rdata=%02h expected %0d/0/9d", obs_lat, obs_to, obs_rdata, TO + 2); end
    endtask

    task automatic test_reset_during_access();
        int  acc = 0;
        int  k;
        bit  seen_rsp = 0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 3'd2; bus.cmd_wdata = 8'h81;
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 50) begin @(negedge PCLK); k++; end
        @(negedge PCLK);
        bus.cmd_valid = 1'b0; bus.PREADY = 1'b0;
        for (k = 0; k < 10 && acc < 2; k++) begin
            if (bus.PSEL && bus.PENABLE) acc++;
            if (acc < 2) @(negedge PCLK);
        end
        tests_run++; if (acc !== 2) begin tests_failed++; $display("FAIL rst_mid_reach_access: got %0d access cycles expected 2", acc); end
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        tests_run++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_state: got psel=%b penable=%b ready=%b expected 0/0/1", bus.PSEL, bus.PENABLE, bus.cmd_ready); end
        for (k = 0; k < 8; k++) begin
            if (bus.rsp_valid === 1'b1) seen_rsp = 1;
            @(negedge PCLK);
        end
        tests_run++; if (seen_rsp !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_rsp: got rsp_valid seen=%b expected 0", seen_rsp); end
        $display("[TB] reset during access: psel=%b ready=%b rsp_seen=%b", bus.PSEL, bus.cmd_ready, seen_rsp);
    endtask

    task automatic test_back_to_back();
        int acc_cyc[2];
        int n = 0;
        int rsp_n = 0;
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b0; bus.PRDATA = 8'h5A;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 3'd1; bus.cmd_wdata = 8'h00;
        acc_cyc[0] = -100; acc_cyc[1] = 100;
        for (int k = 0; k < 20; k++) begin
            if (bus.rsp_valid === 1'b1) rsp_n++;
            if (bus.cmd_ready === 1'b1 && bus.cmd_valid && n < 2) begin
                acc_cyc[n] = cyc;
                n++;
            end
            @(negedge PCLK);
            if (n == 2) bus.cmd_valid = 1'b0;
        end
        bus.PREADY = 1'b0;
        tests_run++; if (acc_cyc[1] - acc_cyc[0] !== 4) begin tests_failed++; $display("FAIL b2b_spacing: got %0d cycles expected 4", acc_cyc[1] - acc_cyc[0]); end
        tests_run++; if (rsp_n !== 2) begin tests_failed++; $display("FAIL b2b_rsp_count: got %0d expected 2", rsp_n); end
        $display("[TB] back-to-back: accepts at %0d and %0d, responses=%0d", acc_cyc[0], acc_cyc[1], rsp_n);
    endtask

    task automatic test_random();
        logic          wr, se;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd, rd;
        int            nw;
        logic          exp_to, exp_err;
        int            exp_lat;
        logic [DW-1:0] exp_rd;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom); se = 1'($urandom); ad = AW'($urandom); wd = DW'($urandom); rd = DW'($urandom);
            nw = $urandom_range(0, TO + 4);
            exp_to  = (TO != 0) && (nw >= TO);
            exp_lat = exp_to ? TO + 2 : 3 + nw;
            exp_err = exp_to ? 1'b1 : se;
            exp_rd  = (exp_to || wr) ? '0 : rd;
            do_xfer(wr, ad, wd, nw, rd, se, 1'($urandom));
            tests_run++; if (obs_lat !== exp_lat) begin tests_failed++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, obs_lat, exp_lat); end
            tests_run++; if (obs_rdata !== exp_rd || obs_err !== exp_err || obs_to !== exp_to) begin tests_failed++; $display("FAIL rand%0d_rsp: got rdata=%02h err=%b to=%b expected %02h/%b/%b", i, obs_rdata, obs_err, obs_to, exp_rd, exp_err, exp_to); end
            tests_run++; if (obs_bus_bad !== 1'b0 || obs_en_bad !== 1'b0 || obs_setup !== 1) begin tests_failed++; $display("FAIL rand%0d_bus: got bad=%b en_bad=%b setup=%0d expected 0/0/1", i, obs_bus_bad, obs_en_bad, obs_setup); end
        end
    endtask

    initial begin
        PRESET = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        @(negedge PCLK);
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slave_error();
        test_timeout();
        test_reset_during_access();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
